formula_tb: RTL and testbench
=============================

Name: formula_tb

Overview:
- Pipelined fixed-point formula evaluator for the homework-4 pipeline set, selected by parameters.
- FORMULA=2 (default build): res = isqrt(a + isqrt(b + isqrt(c))).
- FORMULA=1: res = isqrt(a) + isqrt(b) + isqrt(c).
- Sits between an argument producer and a result consumer. No backpressure: one argument set accepted per cycle, results emitted in order.

Parameters:
- HOMEWORK, 4, homework set id; any value other than 4 is an elaboration error.
- FORMULA, 2, formula select, 1 or 2; other values are an elaboration error.
- PIPE, 1, register density inside each isqrt. 1 = one register per root-bit stage. 0 = one register per two root-bit stages.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- arg_vld  input  1  argument set valid this cycle.
- a  input  32  unsigned operand a.
- b  input  32  unsigned operand b.
- c  input  32  unsigned operand c.
- res_vld  output  1  result valid, exactly one pulse per accepted argument set.
- res  output  32  unsigned result.

Behaviour:
- isqrt(x) = floor(sqrt(x)) for 32-bit unsigned x, giving a 16-bit result zero-extended.
- isqrt uses a restoring bit-by-bit algorithm, 16 root-bit stages, MSB first.
- isqrt latency L: 16 cycles with PIPE=1, 8 cycles with PIPE=0.
- FORMULA=2 datapath:
  - isqrt(c) feeds a combinational add with b; the sum feeds a second isqrt.
  - The second isqrt result adds with a and feeds a third isqrt.
  - b and a are carried in delay lines matched to the isqrt latency.
  - Total latency 3L: 48 cycles with PIPE=1, 24 with PIPE=0.
- FORMULA=1 datapath:
  - Three parallel isqrt units, then a registered three-input sum.
  - Total latency L+1: 17 cycles with PIPE=1, 9 with PIPE=0.
- Additions are 32-bit and wrap modulo 2^32; the carry-out is discarded.
- Throughput: one argument set per cycle. arg_vld may be asserted on every cycle indefinitely.
- Valid travels through a shift register in lockstep with data. res_vld is high exactly latency cycles after each arg_vld.
- Idle cycles (arg_vld=0): data inputs are don't-care, and no res_vld is produced for them.
- res holds its last value when res_vld=0; the consumer must qualify res with res_vld.
- Reset (rst=0): all valid stages clear immediately and res_vld=0. res and all data registers reset to 0.
- Reset mid-operation: in-flight results are discarded and never emitted.
- First arg_vld sampled after rst deasserts yields the first res_vld.

Optional Feature:
- Macro: FORMULA_TB_OVF_EN.
- Defined:
  - Adds output port res_ovf, 1 bit.
  - res_ovf is asserted together with res_vld when any 32-bit addition in that result's path wrapped.
  - res_ovf is 0 when res_vld=0 and 0 in reset.
- Not defined: the port is absent and wrap-around is silent. res and latency are identical in both builds.

Test Plan:
- FORMULA=2, PIPE=1: a=7, b=5, c=16, one cycle -> res_vld pulses at cycle 48 with res=3 (isqrt16=4, 9->3, 10->3).
- FORMULA=2: a=b=c=0 -> res=0. Then a=b=c=32'hFFFFFFFF -> wrapped sums give res=15 (65534->255, 254->15); res_ovf=1 when FORMULA_TB_OVF_EN is defined.
- FORMULA=2: 200 back-to-back random sets with arg_vld held high -> 200 in-order results matching the reference model, one per cycle, none dropped.
- FORMULA=1, PIPE=1: a=1, b=4, c=9 -> res=6 at latency 17; a=b=c=32'hFFFFFFFF -> res=196605.
- PIPE=0 with the same vectors -> identical res values at latency 24 (FORMULA=2) and 9 (FORMULA=1).
- Assert rst=0 with 10 sets in flight, release, then send one set -> no stale res_vld; exactly one correct result.

Source files
------------

// File: rtl/formula_tb.sv
// formula_tb: pipelined fixed-point formula evaluator for the homework-4 set.
//   FORMULA=2: res = isqrt(a + isqrt(b + isqrt(c)))   latency 3L
//   FORMULA=1: res = isqrt(a) + isqrt(b) + isqrt(c)   latency L+1
//   L = 16 with PIPE=1 (register every root-bit stage), 8 with PIPE=0.
// Optional macro FORMULA_TB_OVF_EN adds res_ovf, flagging a wrapped 32-bit add
// somewhere in that result's path. res and latency do not depend on the macro.

// Restoring bit-by-bit integer square root, 16 root-bit stages, MSB first.
// Stage registers only load on valid, so the output holds during idle cycles.
module formula_tb_isqrt #(
  parameter int PIPE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_vld,
  input  logic [31:0] i_x,
  output logic        o_vld,
  output logic [15:0] o_root
);

  for (genvar k = 0; k < 16; k++) begin : g_stage
    localparam int SHIFT = 30 - 2 * k;
    localparam bit REG   = (PIPE != 0) || ((k % 2) == 1);

    logic [31:0] w_xIn;
    logic [17:0] w_remIn;
    logic [15:0] w_rootIn;
    logic        w_vldIn;
    logic [1:0]  w_pair;
    logic [19:0] w_bring;
    logic [19:0] w_trial;
    logic        w_fit;
    logic [15:0] w_rootNext;
    logic [15:0] w_rootOut;
    logic        w_vldOut;

    if (k == 0) begin : g_src
      assign w_xIn    = i_x;
      assign w_remIn  = '0;
      assign w_rootIn = '0;
      assign w_vldIn  = i_vld;
    end else begin : g_src
      assign w_xIn    = g_stage[k-1].g_mid.w_xOut;
      assign w_remIn  = g_stage[k-1].g_mid.w_remOut;
      assign w_rootIn = g_stage[k-1].w_rootOut;
      assign w_vldIn  = g_stage[k-1].w_vldOut;
    end

    // The radicand stays unshifted; each stage picks its own pair of bits.
    assign w_pair     = 2'(w_xIn >> SHIFT);
    assign w_bring    = {w_remIn, w_pair};
    assign w_trial    = {2'b00, w_rootIn, 2'b01};
    assign w_fit      = (w_bring >= w_trial);
    assign w_rootNext = {w_rootIn[14:0], w_fit};

    if (REG) begin : g_reg
      logic        r_vld;
      logic [15:0] r_root;

      // Root and valid move one stage per clock; root only loads on valid.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_vld  <= 1'b0;
          r_root <= '0;
        end else begin
          r_vld <= w_vldIn;
          if (w_vldIn) begin
            r_root <= w_rootNext;
          end
        end
      end

      assign w_vldOut  = r_vld;
      assign w_rootOut = r_root;
    end else begin : g_comb
      assign w_vldOut  = w_vldIn;
      assign w_rootOut = w_rootNext;
    end

    // The last stage needs no radicand or remainder downstream.
    if (k < 15) begin : g_mid
      logic [31:0] w_xOut;
      logic [17:0] w_remOut;
      logic [17:0] w_remNext;

      assign w_remNext = 18'(w_fit ? (w_bring - w_trial) : w_bring);

      if (REG) begin : g_reg
        logic [31:0] r_x;
        logic [17:0] r_rem;

        // Radicand and partial remainder follow the root through the stage.
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            r_x   <= '0;
            r_rem <= '0;
          end else if (w_vldIn) begin
            r_x   <= w_xIn;
            r_rem <= w_remNext;
          end
        end

        assign w_xOut   = r_x;
        assign w_remOut = r_rem;
      end else begin : g_comb
        assign w_xOut   = w_xIn;
        assign w_remOut = w_remNext;
      end
    end
  end

  assign o_vld  = g_stage[15].w_vldOut;
  assign o_root = g_stage[15].w_rootOut;

endmodule

module formula_tb #(
  parameter int HOMEWORK = 4,
  parameter int FORMULA  = 2,
  parameter int PIPE     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arg_vld,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  output logic        res_vld,
`ifdef FORMULA_TB_OVF_EN
  output logic        res_ovf,
`endif
  output logic [31:0] res
);

  localparam int L = (PIPE != 0) ? 16 : 8;

  if (HOMEWORK != 4) begin : g_badHomework
    $error("formula_tb: HOMEWORK must be 4");
  end

  if (FORMULA == 2) begin : g_nested
    logic        w_vld1, w_vld2, w_vld3;
    logic [15:0] w_root1, w_root2, w_root3;
    logic [31:0] w_sum2, w_sum3;
    logic [L-1:0][31:0]   r_bDly;
    logic [2*L-1:0][31:0] r_aDly;

    formula_tb_isqrt #(.PIPE(PIPE)) u_sqrtC (
      .clk(clk), .rst(rst), .i_vld(arg_vld), .i_x(c),
      .o_vld(w_vld1), .o_root(w_root1)
    );

    // b waits one isqrt latency, a waits two, so each meets its partner root.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_bDly <= '0;
        r_aDly <= '0;
      end else begin
        r_bDly <= {r_bDly[L-2:0], b};
        r_aDly <= {r_aDly[2*L-2:0], a};
      end
    end

`ifdef FORMULA_TB_OVF_EN
    logic         w_carry2, w_carry3;
    logic [L-1:0] r_ovf2Dly, r_ovf3Dly;

    assign {w_carry2, w_sum2} = {1'b0, r_bDly[L-1]} + {17'b0, w_root1};
    assign {w_carry3, w_sum3} = {1'b0, r_aDly[2*L-1]} + {17'b0, w_root2};

    // Wrap flags ride alongside the remaining isqrt stages of their result.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_ovf2Dly <= '0;
        r_ovf3Dly <= '0;
      end else begin
        r_ovf2Dly <= {r_ovf2Dly[L-2:0], w_carry2};
        r_ovf3Dly <= {r_ovf3Dly[L-2:0], w_carry3 | r_ovf2Dly[L-1]};
      end
    end

    assign res_ovf = w_vld3 & r_ovf3Dly[L-1];
`else
    assign w_sum2 = r_bDly[L-1] + {16'b0, w_root1};
    assign w_sum3 = r_aDly[2*L-1] + {16'b0, w_root2};
`endif

    formula_tb_isqrt #(.PIPE(PIPE)) u_sqrtB (
      .clk(clk), .rst(rst), .i_vld(w_vld1), .i_x(w_sum2),
      .o_vld(w_vld2), .o_root(w_root2)
    );

    formula_tb_isqrt #(.PIPE(PIPE)) u_sqrtA (
      .clk(clk), .rst(rst), .i_vld(w_vld2), .i_x(w_sum3),
      .o_vld(w_vld3), .o_root(w_root3)
    );

    assign res_vld = w_vld3;
    assign res     = {16'b0, w_root3};
  end else if (FORMULA == 1) begin : g_parallel
    logic        w_vldA, w_vldB, w_vldC;
    logic [15:0] w_rootA, w_rootB, w_rootC;
    logic        r_resVld;
    logic [31:0] r_res;

    formula_tb_isqrt #(.PIPE(PIPE)) u_sqrtA (
      .clk(clk), .rst(rst), .i_vld(arg_vld), .i_x(a),
      .o_vld(w_vldA), .o_root(w_rootA)
    );
    formula_tb_isqrt #(.PIPE(PIPE)) u_sqrtB (
      .clk(clk), .rst(rst), .i_vld(arg_vld), .i_x(b),
      .o_vld(w_vldB), .o_root(w_rootB)
    );
    formula_tb_isqrt #(.PIPE(PIPE)) u_sqrtC (
      .clk(clk), .rst(rst), .i_vld(arg_vld), .i_x(c),
      .o_vld(w_vldC), .o_root(w_rootC)
    );

    // Registered three-way sum; three 16-bit roots can never wrap 32 bits.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_resVld <= 1'b0;
        r_res    <= '0;
      end else begin
        r_resVld <= w_vldA & w_vldB & w_vldC;
        if (w_vldA) begin
          r_res <= {16'b0, w_rootA} + {16'b0, w_rootB} + {16'b0, w_rootC};
        end
      end
    end

    assign res_vld = r_resVld;
    assign res     = r_res;
`ifdef FORMULA_TB_OVF_EN
    assign res_ovf = 1'b0;
`endif
  end else begin : g_badFormula
    $error("formula_tb: FORMULA must be 1 or 2");
    assign res_vld = 1'b0;
    assign res     = '0;
`ifdef FORMULA_TB_OVF_EN
    assign res_ovf = 1'b0;
`endif
  end

endmodule

// File: tb/tb_formula_tb.sv
// tb_formula_tb: drives four formula_tb builds (F2/P1, F1/P1, F2/P0, F1/P0)
// with one shared stimulus stream and scoreboards each against a reference model.
// With FORMULA_TB_OVF_EN defined, res_ovf is checked as well.
module tb_formula_tb;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    int          due;
  } expT;

  logic             clk = 1'b0;
  logic             rst;
  logic             argVld;
  logic [31:0]      a, b, c;
  logic [3:0]       resVld;
  logic [3:0][31:0] resArr;
  logic [3:0]       resOvf;

  int   edges  = 0;
  int   checks = 0;
  int   errors = 0;
  expT  sb [4][$];
  logic [31:0] lastRes [4];

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  // Counts rising edges so scoreboard entries can carry their due edge
  always @(posedge clk) edges <= edges + 1;

  formula_tb #(.HOMEWORK(4), .FORMULA(2), .PIPE(1)) u_f2p1 (
    .clk(clk), .rst(rst), .arg_vld(argVld), .a(a), .b(b), .c(c),
    .res_vld(resVld[0]),
`ifdef FORMULA_TB_OVF_EN
    .res_ovf(resOvf[0]),
`endif
    .res(resArr[0]));

  formula_tb #(.HOMEWORK(4), .FORMULA(1), .PIPE(1)) u_f1p1 (
    .clk(clk), .rst(rst), .arg_vld(argVld), .a(a), .b(b), .c(c),
    .res_vld(resVld[1]),
`ifdef FORMULA_TB_OVF_EN
    .res_ovf(resOvf[1]),
`endif
    .res(resArr[1]));

  formula_tb #(.HOMEWORK(4), .FORMULA(2), .PIPE(0)) u_f2p0 (
    .clk(clk), .rst(rst), .arg_vld(argVld), .a(a), .b(b), .c(c),
    .res_vld(resVld[2]),
`ifdef FORMULA_TB_OVF_EN
    .res_ovf(resOvf[2]),
`endif
    .res(resArr[2]));

  formula_tb #(.HOMEWORK(4), .FORMULA(1), .PIPE(0)) u_f1p0 (
    .clk(clk), .rst(rst), .arg_vld(argVld), .a(a), .b(b), .c(c),
    .res_vld(resVld[3]),
`ifdef FORMULA_TB_OVF_EN
    .res_ovf(resOvf[3]),
`endif
    .res(resArr[3]));

`ifndef FORMULA_TB_OVF_EN
  assign resOvf = '0;
`endif

  function automatic int latOf(input int d);
    case (d)
      0:       return 48;
      1:       return 17;
      2:       return 24;
      default: return 9;
    endcase
  endfunction

  function automatic int formulaOf(input int d);
    return (d % 2 == 0) ? 2 : 1;
  endfunction

  // Square root by trial squaring, independent of the restoring hardware
  function automatic logic [31:0] isqrtRef(input logic [31:0] x);
    logic [31:0] r;
    logic [63:0] t;
    r = '0;
    for (int bitIdx = 15; bitIdx >= 0; bitIdx--) begin
      t = {32'b0, r | (32'd1 << bitIdx)};
      if (t * t <= {32'b0, x}) r = t[31:0];
    end
    return r;
  endfunction

  function automatic void model(input int f, input logic [31:0] ia, ib, ic,
                                output logic [31:0] r, output logic ovf);
    logic [32:0] s;
    if (f == 2) begin
      s   = {1'b0, ib} + {1'b0, isqrtRef(ic)};
      ovf = s[32];
      s   = {1'b0, ia} + {1'b0, isqrtRef(s[31:0])};
      ovf = ovf | s[32];
      r   = isqrtRef(s[31:0]);
    end else begin
      r   = isqrtRef(ia) + isqrtRef(ib) + isqrtRef(ic);
      ovf = 1'b0;
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Drives one cycle of inputs and queues the expected result per build
  task automatic applyStimulus(input logic v, input logic [31:0] ia, ib, ic);
    expT item;
    @(posedge clk);
    #1;
    argVld = v;
    a = ia;
    b = ib;
    c = ic;
    if (v) begin
      for (int d = 0; d < 4; d++) begin
        model(formulaOf(d), ia, ib, ic, item.res, item.ovf);
        item.due = edges + latOf(d);
        sb[d].push_back(item);
      end
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, $urandom, $urandom, $urandom);
  endtask

  // Scoreboard monitor, sampled on the falling edge away from the active edge
  always @(negedge clk) begin
    for (int d = 0; d < 4; d++) begin
      if (!rst) begin
        checkOutput($sformatf("reset_vld[%0d]", d), {31'b0, resVld[d]}, 32'd0);
        checkOutput($sformatf("reset_res[%0d]", d), resArr[d], 32'd0);
        checkOutput($sformatf("reset_ovf[%0d]", d), {31'b0, resOvf[d]}, 32'd0);
        lastRes[d] = '0;
      end else if (sb[d].size() > 0 && sb[d][0].due == edges) begin
        expT e;
        e = sb[d].pop_front();
        checkOutput($sformatf("res_vld[%0d]@%0d", d, edges), {31'b0, resVld[d]}, 32'd1);
        checkOutput($sformatf("res[%0d]@%0d", d, edges), resArr[d], e.res);
`ifdef FORMULA_TB_OVF_EN
        checkOutput($sformatf("res_ovf[%0d]@%0d", d, edges), {31'b0, resOvf[d]}, {31'b0, e.ovf});
`endif
        lastRes[d] = e.res;
      end else begin
        checkOutput($sformatf("idle_vld[%0d]@%0d", d, edges), {31'b0, resVld[d]}, 32'd0);
        checkOutput($sformatf("hold_res[%0d]@%0d", d, edges), resArr[d], lastRes[d]);
`ifdef FORMULA_TB_OVF_EN
        checkOutput($sformatf("idle_ovf[%0d]@%0d", d, edges), {31'b0, resOvf[d]}, 32'd0);
`endif
      end
    end
  end

  initial begin
    rst    = 1'b0;
    argVld = 1'b0;
    a      = '0;
    b      = '0;
    c      = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    $display("[TB] single set a=7 b=5 c=16");
    applyStimulus(1'b1, 32'd7, 32'd5, 32'd16);
    idleCycles(60);

    $display("[TB] zeros then all-ones");
    applyStimulus(1'b1, 32'd0, 32'd0, 32'd0);
    applyStimulus(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    applyStimulus(1'b1, 32'd1, 32'd4, 32'd9);
    idleCycles(60);

    $display("[TB] 200 back-to-back random sets");
    for (int i = 0; i < 200; i++) begin
      if (i % 2 == 0) applyStimulus(1'b1, $urandom, $urandom, $urandom);
      else applyStimulus(1'b1, $urandom_range(0, 5000), $urandom_range(0, 5000),
                         $urandom_range(0, 5000));
    end
    idleCycles(60);

    $display("[TB] reset with sets in flight");
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, $urandom, $urandom, $urandom);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    argVld = 1'b0;
    for (int d = 0; d < 4; d++) sb[d].delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    applyStimulus(1'b1, 32'd100, 32'd200, 32'd300);
    idleCycles(60);

    for (int d = 0; d < 4; d++)
      checkOutput($sformatf("drain[%0d]", d), sb[d].size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
